writeback_unit: RTL

- Write-back end of the register-file write interface. Sole producer of `regWrite` / `writeRegister` / `writeData`, which the operand-prep register file consumes.
- Accepts completed results from execute (ALU results or load requests).
- Waits for load data from data memory.
- Queues committed writes in a small FIFO and drains at most one register write per clock.
- Discards writes to XZR (register 31).

---
 rtl/writeback_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Write-back end of the register-file write path. Accepts completed results
// from execute (ALU results or load requests), waits for load data from data
// memory, queues committed writes in a small FIFO and drains at most one
// register write per clock. Writes to XZR (register 31) are discarded.
//
// Optional feature (macro WB_FORWARD_EN): combinational forwarding lookup over
// the queued writes and the current output stage.
//
// Ports:
//   clock, reset_n           main clock, asynchronous active-low reset
//   resultValid/resultReady  result handshake from execute
//   regWriteIn, memToReg     result writes a register / result is a load
//   destReg, aluResult       destination register and ALU value
//   memData, memDataValid    load data and its single-cycle valid pulse
//   regWrite, writeRegister,
//   writeData                registered write port to the register file
//   fifoCount                current write FIFO occupancy
//   busy                     FSM not idle or writes still queued
//   lookupReg, fwdHit,
//   fwdData                  forwarding lookup (WB_FORWARD_EN only)
// -----------------------------------------------------------------------------
module writeback_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          resultValid,
    output logic          resultReady,
    input  logic          regWriteIn,
    input  logic          memToReg,
    input  logic [4:0]    destReg,
    input  logic [31:0]   aluResult,
    input  logic [31:0]   memData,
    input  logic          memDataValid,
    output logic          regWrite,
    output logic [4:0]    writeRegister,
    output logic [31:0]   writeData,
    output logic [AW:0]   fifoCount,
    output logic          busy
`ifdef WB_FORWARD_EN
    ,
    input  logic [4:0]    lookupReg,
    output logic          fwdHit,
    output logic [31:0]   fwdData
`endif
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [4:0]  XZR     = 5'd31;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, HOLD} state_t;

    state_t        state_q, state_d;
    logic [4:0]    load_reg_q, load_reg_d;
    logic [31:0]   hold_data_q, hold_data_d;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          reg_write_q;
    logic [4:0]    write_reg_q;
    logic [31:0]   write_data_q;

    logic [4:0]    fifo_reg_q  [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];

    logic          accept, discard, pop, space, push;
    logic [4:0]    push_reg;
    logic [31:0]   push_data;

    assign resultReady = (state_q == IDLE) && (count_q < DEPTH_C);
    assign accept      = resultValid && resultReady;
    assign discard     = !regWriteIn || (destReg == XZR);
    assign pop         = (count_q != '0);
    // Space is judged after this edge's pop, so a full FIFO that drains can
    // still take a push on the same edge.
    assign space       = (count_q < DEPTH_C) || pop;
    assign count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);

    // NOTE: every signal written here gets a default first, so no latches.
    always_comb begin
        state_d     = state_q;
        load_reg_d  = load_reg_q;
        hold_data_d = hold_data_q;
        push        = 1'b0;
        push_reg    = load_reg_q;
        push_data   = hold_data_q;
        unique case (state_q)
            IDLE: begin
                // resultReady already guarantees room for an ALU push.
                if (accept && !discard) begin
                    if (memToReg) begin
                        load_reg_d = destReg;
                        state_d    = WAIT_MEM;
                    end else begin
                        push      = 1'b1;
                        push_reg  = destReg;
                        push_data = aluResult;
                    end
                end
            end
            WAIT_MEM: begin
                if (memDataValid) begin
                    if (space) begin
                        push      = 1'b1;
                        push_data = memData;
                        state_d   = IDLE;
                    end else begin
                        hold_data_d = memData;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (space) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            load_reg_q   <= '0;
            hold_data_q  <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            state_q     <= state_d;
            load_reg_q  <= load_reg_d;
            hold_data_q <= hold_data_d;
            count_q     <= count_d;
            reg_write_q <= pop;
            if (pop) begin
                write_reg_q  <= fifo_reg_q[rd_ptr_q];
                write_data_q <= fifo_data_q[rd_ptr_q];
                rd_ptr_q     <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
        end
    end

    // NOTE: FIFO storage is not reset; the occupancy count alone says which
    // entries are valid, so reset only has to clear the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_reg_q[wr_ptr_q]  <= push_reg;
            fifo_data_q[wr_ptr_q] <= push_data;
        end
    end

    assign regWrite      = reg_write_q;
    assign writeRegister = write_reg_q;
    assign writeData     = write_data_q;
    assign fifoCount     = count_q;
    assign busy          = (state_q != IDLE) || (count_q != '0);

`ifdef WB_FORWARD_EN
    // Scan from oldest (output stage) to youngest (tail) so that later
    // matches override earlier ones.
    logic [AW-1:0] fwd_idx;
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        fwd_idx = rd_ptr_q;
        if (reg_write_q && (write_reg_q == lookupReg)) begin
            fwdHit  = 1'b1;
            fwdData = write_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + AW'(i);
            if (((AW+1)'(i) < count_q) && (fifo_reg_q[fwd_idx] == lookupReg)) begin
                fwdHit  = 1'b1;
                fwdData = fifo_data_q[fwd_idx];
            end
        end
        if (lookupReg == XZR) begin
            fwdHit  = 1'b0;
            fwdData = '0;
        end
    end
`endif

endmodule
